// File: rtl/fadd_seq_ctrl_if.sv
// Handshake bundle for the add/sub sequencer: operand channel, result channel,
// plus status and an FSM state tap for checkers.
interface fadd_seq_ctrl_if;
    // Both channels are valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both 1; the source holds its payload while
    // valid=1 and ready=0.
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        busy;
    logic [2:0]  fsm_state;

    modport master (
        output in_valid, op_a, op_b, sub, res_ready,
        input  in_ready, res_valid, result, busy, fsm_state
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, res_ready,
        output in_ready, res_valid, result, busy, fsm_state
    );
endinterface

// File: rtl/fadd_seq_ctrl.sv
// Multi-cycle binary32 add/sub sequencer: unpack, align one bit per cycle,
// two's-complement add, normalize one bit per cycle, pack and hold.
module fadd_seq_ctrl #(
    parameter int MAX_ALIGN = 25
) (
    input  logic           clk,
    input  logic           rst,
    fadd_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] MAX_ALIGN_V = 8'(MAX_ALIGN);

    state_t state, state_nxt;

    // Working registers: "big" is the larger-exponent operand, "sm" the one
    // being shifted during alignment.
    logic        s_big, s_sm;
    logic [23:0] m_big, m_sm;
    logic [7:0]  cnt;
    logic [7:0]  exp_r;
    logic        sign_r;
    logic [23:0] mag_r;
    logic [31:0] result_r;

    // Operand unpack
    logic [7:0]  ea, eb, diff, cnt_in;
    logic [23:0] ma, mb;
    logic        sa, sb, a_big;
    logic        a_nan, b_nan, a_inf, b_inf, is_special;
    logic [31:0] special_res;

    always_comb begin
        ea     = bus.op_a[30:23];
        eb     = bus.op_b[30:23];
        sa     = bus.op_a[31];
        sb     = bus.op_b[31] ^ bus.sub;
        ma     = (ea == 8'd0) ? 24'd0 : {1'b1, bus.op_a[22:0]};
        mb     = (eb == 8'd0) ? 24'd0 : {1'b1, bus.op_b[22:0]};
        a_big  = (ea >= eb);
        diff   = a_big ? (ea - eb) : (eb - ea);
        cnt_in = (diff >= MAX_ALIGN_V) ? MAX_ALIGN_V : diff;
        a_nan  = (ea == 8'hFF) && (bus.op_a[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (bus.op_b[22:0] != 23'd0);
        a_inf  = (ea == 8'hFF) && (bus.op_a[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (bus.op_b[22:0] == 23'd0);
        is_special = (ea == 8'hFF) || (eb == 8'hFF);
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            special_res = 32'h7FC0_0000;
        else if (a_inf)
            special_res = {sa, 8'hFF, 23'd0};
        else
            special_res = {sb, 8'hFF, 23'd0};
    end

    // Add stage: 26-bit two's complement with one overflow-extension bit
    logic [25:0] op_big, op_sm, sum;
    logic [24:0] mag_sum;
    logic [23:0] mag_add;
    logic [7:0]  exp_add;
    logic        ovf;

    always_comb begin
        op_big  = s_big ? -{2'b00, m_big} : {2'b00, m_big};
        op_sm   = s_sm  ? -{2'b00, m_sm}  : {2'b00, m_sm};
        sum     = op_big + op_sm;
        mag_sum = sum[25] ? 25'(-sum) : sum[24:0];
        if (mag_sum[24]) begin
            mag_add = mag_sum[24:1];
            exp_add = exp_r + 8'd1;
        end else begin
            mag_add = mag_sum[23:0];
            exp_add = exp_r;
        end
        ovf = mag_sum[24] && (exp_r == 8'hFE);
    end

    logic norm_done;
    assign norm_done = (mag_r == 24'd0) || mag_r[23] || (exp_r == 8'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.in_valid) state_nxt = is_special ? DONE : ALIGN;
            ALIGN: if (cnt == 8'd0)  state_nxt = ADD;
            ADD:   state_nxt = ovf ? DONE : NORM;
            NORM:  if (norm_done)    state_nxt = DONE;
            DONE:  if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.res_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.fsm_state = state;
        bus.result    = result_r;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_big    <= 1'b0;
            s_sm     <= 1'b0;
            m_big    <= 24'd0;
            m_sm     <= 24'd0;
            cnt      <= 8'd0;
            exp_r    <= 8'd0;
            sign_r   <= 1'b0;
            mag_r    <= 24'd0;
            result_r <= 32'd0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    if (a_big) begin
                        s_big <= sa; m_big <= ma;
                        s_sm  <= sb; m_sm  <= mb;
                        exp_r <= ea;
                    end else begin
                        s_big <= sb; m_big <= mb;
                        s_sm  <= sa; m_sm  <= ma;
                        exp_r <= eb;
                    end
                    cnt <= cnt_in;
                    if (is_special) result_r <= special_res;
                end
                ALIGN: if (cnt != 8'd0) begin
                    m_sm <= m_sm >> 1;
                    cnt  <= cnt - 8'd1;
                end
                ADD: begin
                    sign_r <= sum[25];
                    mag_r  <= mag_add;
                    exp_r  <= exp_add;
                    if (ovf) result_r <= {sum[25], 8'hFF, 23'd0};
                end
                NORM: begin
                    // A zero magnitude always yields +0, even for -0 + -0.
                    if (mag_r == 24'd0)
                        result_r <= 32'd0;
                    else if (mag_r[23])
                        result_r <= {sign_r, exp_r, mag_r[22:0]};
                    else if (exp_r == 8'd1)
                        result_r <= {sign_r, 31'd0};
                    else begin
                        mag_r <= {mag_r[22:0], 1'b0};
                        exp_r <= exp_r - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_seq_ctrl.sv
// Directed vector bench for fadd_seq_ctrl: result and latency table plus
// backpressure and asynchronous-reset sequences.
module tb_fadd_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fadd_seq_ctrl_if bus();

    fadd_seq_ctrl #(.MAX_ALIGN(25)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // lat = rising edges after the accepting edge until res_valid is seen
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.sub      = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.sub      = 1'($urandom_range(0, 1));
        lat = 0;
        while (!bus.res_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.res_valid) begin
            failures++;
            checks++;
            $display("FAIL timeout waiting for res_valid a=%h b=%h", a, b);
        end
        res = bus.result;
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({name, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;

        bus.in_valid  = 1'b0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.sub       = 1'b0;
        bus.res_ready = 1'b0;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3};  // 1+1
        vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4};  // 3-1
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3};  // 1-1
        vecs[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 28}; // diff 30
        vecs[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 0};  // inf-inf
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2};  // overflow
        vecs[6]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 0};  // NaN in
        vecs[7]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 0};  // -inf+1
        vecs[8]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 0};  // inf-inf via sub
        vecs[9]  = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3};  // 1-(-1)
        vecs[10] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 3};  // 0+0
        vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 3};  // -0+-0
        vecs[12] = '{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 5};  // 1-0.5
        vecs[13] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3};  // 1.5+1.5
        vecs[14] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3};  // flush to -0
        vecs[15] = '{32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 5};  // 2+(-1)

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, res, lat);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            finish_op($sformatf("v%0d", i));
        end

        // Backpressure: result held, new requests ignored
        run_op(32'h3F800000, 32'h3F800000, 1'b0, res, lat);
        check("bp_result", res, 32'h40000000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.op_a     = $urandom;
            bus.op_b     = $urandom;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_res_valid", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("bp%0d_result", i), bus.result, 32'h40000000);
            check($sformatf("bp%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        finish_op("bp_release");

        // Asynchronous reset in the middle of a long alignment
        @(negedge clk);
        bus.op_a     = 32'h3F800000;
        bus.op_b     = 32'h30800000;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("ar_state_align", 32'(bus.fsm_state), 32'd1);
        check("ar_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_in_ready", 32'(bus.in_ready), 32'd1);
        check("ar_res_valid", 32'(bus.res_valid), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, res, lat);
        check("post_rst_result", res, 32'h40000000);
        check("post_rst_latency", 32'(lat), 32'd3);
        finish_op("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
